// File: rtl/ksa_pipe_if.sv
// Operand/result stream bundle for the pipelined Kogge-Stone adder.
// The slave side is the adder; the master side is whatever feeds it and drains it.
interface ksa_pipe_if #(
  parameter int unsigned WIDTH = 24
);
  logic             i_valid;
  logic             o_ready;
  logic             c0;
  logic             i_sub;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_s;
  logic             o_carry;
  logic             o_ovf;

  modport slave (
    input  i_valid, c0, i_sub, i_a, i_b, i_ready,
    output o_ready, o_valid, o_s, o_carry, o_ovf
  );

  modport master (
    output i_valid, c0, i_sub, i_a, i_b, i_ready,
    input  o_ready, o_valid, o_s, o_carry, o_ovf
  );
endinterface

// File: rtl/ksa_pipe.sv
// Pipelined Kogge-Stone adder/subtractor: one register per prefix level plus
// input (g/p) and output (sum) stages; the whole pipe freezes on output backpressure.
module ksa_pipe #(
  parameter int unsigned WIDTH = 24
) (
  input logic       i_clk,
  input logic       i_rst_n,
  ksa_pipe_if.slave bus
);
  localparam int unsigned LEVELS = $clog2(WIDTH);

  logic             stall;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] g_in;
  logic [WIDTH-1:0] p_in;
  logic             cin_in;

  // Index 0 is the g/p stage, index k holds the result of prefix level k.
  logic [WIDTH-1:0] g_q   [0:LEVELS];
  logic [WIDTH-1:0] p_q   [0:LEVELS];
  logic [WIDTH-1:0] po_q  [0:LEVELS];
  logic             cin_q [0:LEVELS];
  logic             v_q   [0:LEVELS];
  logic [WIDTH-1:0] g_n   [1:LEVELS];
  logic [WIDTH-1:0] p_n   [1:LEVELS];

  logic [WIDTH-1:0] gp;
  logic [WIDTH-1:0] s_next;
  logic [WIDTH-1:0] s_q;
  logic             ov_q;
  logic             carry_q;
  logic             ovf_q;

  assign stall       = ov_q & ~bus.i_ready;
  assign bus.o_ready = ~stall;

  // Carry-in enters as a bit -1 generate, merged into bit 0 here so that every
  // prefix reaching bit 0 already includes it.
  always_comb begin
    b_eff   = bus.i_sub ? ~bus.i_b : bus.i_b;
    cin_in  = bus.i_sub | bus.c0;
    p_in    = bus.i_a ^ b_eff;
    g_in    = bus.i_a & b_eff;
    g_in[0] = g_in[0] | (p_in[0] & cin_in);
  end

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int unsigned      SPAN = 1 << (k - 1);
    localparam logic [WIDTH-1:0] LOW  = ~({WIDTH{1'b1}} << SPAN);
    assign g_n[k] = g_q[k-1] | (p_q[k-1] & (g_q[k-1] << SPAN));
    assign p_n[k] = p_q[k-1] & ((p_q[k-1] << SPAN) | LOW);
  end

  assign gp     = g_q[LEVELS];
  assign s_next = po_q[LEVELS] ^ {gp[WIDTH-2:0], cin_q[LEVELS]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned k = 0; k <= LEVELS; k++) begin
        g_q[k]   <= '0;
        p_q[k]   <= '0;
        po_q[k]  <= '0;
        cin_q[k] <= 1'b0;
        v_q[k]   <= 1'b0;
      end
      s_q     <= '0;
      ov_q    <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (!stall) begin
      v_q[0]   <= bus.i_valid;
      g_q[0]   <= g_in;
      p_q[0]   <= p_in;
      po_q[0]  <= p_in;
      cin_q[0] <= cin_in;
      for (int unsigned k = 1; k <= LEVELS; k++) begin
        v_q[k]   <= v_q[k-1];
        g_q[k]   <= g_n[k];
        p_q[k]   <= p_n[k];
        po_q[k]  <= po_q[k-1];
        cin_q[k] <= cin_q[k-1];
      end
      ov_q    <= v_q[LEVELS];
      s_q     <= s_next;
      carry_q <= gp[WIDTH-1];
      ovf_q   <= gp[WIDTH-1] ^ gp[WIDTH-2];
    end
  end

  assign bus.o_valid = ov_q;
  assign bus.o_s     = s_q;
  assign bus.o_carry = carry_q;
  assign bus.o_ovf   = ovf_q;
endmodule

// File: tb/tb_ksa_pipe.sv
// Directed bench for ksa_pipe at WIDTH=24: reset state, corner arithmetic,
// latency, backpressure streaming and mid-flight reset.
module tb_ksa_pipe;
  localparam int unsigned W   = 24;
  localparam int          LAT = 7;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  ksa_pipe_if #(.WIDTH(W)) bus ();

  ksa_pipe #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [25:0] model(input logic [23:0] a, input logic [23:0] b,
                                        input logic c, input logic sub);
    logic [23:0] be;
    logic [24:0] r;
    logic        ovf;
    be  = sub ? ~b : b;
    r   = {1'b0, a} + {1'b0, be} + {24'd0, (sub | c)};
    ovf = (a[23] == be[23]) && (r[23] != a[23]);
    return {ovf, r[24], r[23:0]};
  endfunction

  // Entered at a negedge; sends one beat and waits for its result.
  task automatic run_vec(input logic [23:0] a, input logic [23:0] b, input logic c,
                         input logic sub, input logic [23:0] es, input logic ec,
                         input logic eo);
    int n;
    bus.i_a = a; bus.i_b = b; bus.c0 = c; bus.i_sub = sub; bus.i_valid = 1'b1;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    while (!bus.o_valid && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("latency", n, LAT);
    check("sum", bus.o_s, es);
    check("carry", bus.o_carry, ec);
    check("ovf", bus.o_ovf, eo);
  endtask

  logic [23:0] a_s   [10];
  logic [23:0] b_s   [10];
  logic        c_s   [10];
  logic        sub_s [10];
  logic [25:0] exp_q [$];
  logic [25:0] held;
  logic [25:0] e;
  int          cyc, sent, got;

  initial begin
    rst_n = 1'b0;
    bus.i_valid = 1'b0; bus.i_ready = 1'b1; bus.c0 = 1'b0; bus.i_sub = 1'b0;
    bus.i_a = '0; bus.i_b = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", bus.o_valid, 1'b0);
    check("rst_s", bus.o_s, 24'h0);
    check("rst_carry", bus.o_carry, 1'b0);
    check("rst_ovf", bus.o_ovf, 1'b0);
    check("rst_ready", bus.o_ready, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", bus.o_ready, 1'b1);

    run_vec(24'hFFFFFF, 24'h000001, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0);
    run_vec(24'h000005, 24'h000007, 1'b0, 1'b1, 24'hFFFFFE, 1'b0, 1'b0);
    run_vec(24'h000007, 24'h000005, 1'b0, 1'b1, 24'h000002, 1'b1, 1'b0);
    run_vec(24'h7FFFFF, 24'h000001, 1'b0, 1'b0, 24'h800000, 1'b0, 1'b1);
    run_vec(24'h800000, 24'h000001, 1'b0, 1'b1, 24'h7FFFFF, 1'b1, 1'b1);
    run_vec(24'h123456, 24'h654321, 1'b1, 1'b0, 24'h777778, 1'b0, 1'b0);
    run_vec(24'h000010, 24'h000010, 1'b1, 1'b1, 24'h000000, 1'b1, 1'b0);
    run_vec(24'h800000, 24'h800000, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b1);
    run_vec(24'h000000, 24'h000000, 1'b1, 1'b0, 24'h000001, 1'b0, 1'b0);
    run_vec(24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b0, 24'hFFFFFF, 1'b1, 1'b0);

    // Back-to-back stream with i_ready low during cycles 9..11.
    for (int i = 0; i < 10; i++) begin
      a_s[i]   = 24'($urandom);
      b_s[i]   = 24'($urandom);
      c_s[i]   = 1'($urandom);
      sub_s[i] = 1'($urandom);
    end
    @(negedge clk);
    cyc = 0; sent = 0; got = 0; held = '0;
    while (got < 10 && cyc < 80) begin
      bus.i_ready = !(cyc >= 9 && cyc <= 11);
      if (sent < 10) begin
        bus.i_a = a_s[sent]; bus.i_b = b_s[sent]; bus.c0 = c_s[sent];
        bus.i_sub = sub_s[sent]; bus.i_valid = 1'b1;
      end else begin
        bus.i_valid = 1'b0;
      end
      #1;
      if (cyc >= 9 && cyc <= 11) begin
        check("stall_ready", bus.o_ready, 1'b0);
        check("stall_valid", bus.o_valid, 1'b1);
        if (cyc == 9) held = {bus.o_ovf, bus.o_carry, bus.o_s};
        else check("stall_hold", {bus.o_ovf, bus.o_carry, bus.o_s}, held);
      end else if (cyc < 20) begin
        check("stream_ready", bus.o_ready, 1'b1);
      end
      if (bus.o_valid && bus.i_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 26'h3FFFFFF;
        check("stream_result", {bus.o_ovf, bus.o_carry, bus.o_s}, e);
        got++;
      end
      if (bus.i_valid && bus.o_ready) begin
        exp_q.push_back(model(a_s[sent], b_s[sent], c_s[sent], sub_s[sent]));
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    check("stream_count", got, 10);
    check("stream_leftover", exp_q.size(), 0);

    // Four beats in flight, then a one-cycle reset pulse.
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.i_a = 24'h000100 + 24'(i); bus.i_b = 24'h000001; bus.c0 = 1'b0;
      bus.i_sub = 1'b0; bus.i_valid = 1'b1;
      @(negedge clk);
    end
    bus.i_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", bus.o_valid, 1'b0);
    check("midrst_ready", bus.o_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge clk);
      check("flushed_valid", bus.o_valid, 1'b0);
    end

    run_vec(24'h0000FF, 24'h000001, 1'b0, 1'b0, 24'h000100, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ksa_pipe.md
KSA_PIPE -- requirements
Module: ksa_pipe

Interface
REQ-001 Parameter WIDTH, default 24, operand/sum width; legal range 2..64.
REQ-002 Derived constant LEVELS = ceil(log2(WIDTH)) is the number of prefix levels; LAT = LEVELS + 2 is the pipeline latency in cycles (7 at WIDTH=24).
REQ-003 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_valid  input  1  upstream operand beat valid.
REQ-006 o_ready  output  1  block accepts a beat this cycle.
REQ-007 c0  input  1  carry-in, sampled with the operands.
REQ-008 i_sub  input  1  mode: 0 = a+b+c0, 1 = a-b (a + ~b + 1, c0 ignored).
REQ-009 i_a  input  WIDTH  operand A.
REQ-010 i_b  input  WIDTH  operand B.
REQ-011 o_valid  output  1  result beat valid.
REQ-012 i_ready  input  1  downstream accepts the result beat.
REQ-013 o_s  output  WIDTH  sum/difference.
REQ-014 o_carry  output  1  carry-out of MSB; in subtract mode 1 = no borrow.
REQ-015 o_ovf  output  1  two's-complement signed overflow of the result.

Function
REQ-016 Stage 0 registers the generate/propagate terms g=a&b', p=a^b' with b'=i_sub?~i_b:i_b and effective carry-in cin=i_sub?1:c0.
REQ-017 Stages 1..LEVELS each register one Kogge-Stone prefix level with span 2^(k-1): (G,P)[i] = (G[i] | P[i]&G[i-span], P[i]&P[i-span]) for i>=span; otherwise pass-through; cin folded in as bit -1 generate.
REQ-018 Final stage registers o_s[i] = p[i] ^ Gprefix[i-1] (bit 0 uses cin), o_carry = Gprefix[WIDTH-1], o_ovf = carry into MSB XOR carry out of MSB.
REQ-019 Each stage carries a valid bit plus the original p vector and operand MSBs needed downstream; no operand field is recomputed later.
REQ-020 Beat accepted when i_valid & o_ready; result presented exactly LAT cycles after acceptance absent stalls.
REQ-021 stall = o_valid & ~i_ready; o_ready = ~stall (combinational, no dependence on i_valid).
REQ-022 During stall every stage, including valid bits, holds its value; o_s/o_carry/o_ovf stable while o_valid=1 and i_ready=0.
REQ-023 When not stalled all stages advance every cycle; a cycle with no accepted beat inserts a bubble (valid=0).
REQ-024 Sustained throughput is one result per cycle when i_valid and i_ready are both held high.
REQ-025 Results leave in acceptance order; no beat dropped or duplicated under any i_valid/i_ready pattern.
REQ-026 Simultaneous output handshake and input acceptance in the same cycle both complete.
REQ-027 Arithmetic wraps modulo 2^WIDTH; o_carry reports the lost bit; 0xFFFFFF+1 at WIDTH=24 yields o_s=0, o_carry=1.
REQ-028 Data fields of invalid stages are don't-care but never X-propagate into valid beats.

Reset
REQ-029 i_rst_n low asynchronously clears all stage valid bits; o_valid=0, o_s=0, o_carry=0, o_ovf=0 while held low.
REQ-030 o_ready reads 1 during and after reset (no valid beat at output).
REQ-031 Reset mid-operation discards all in-flight beats; none emerge after release.
REQ-032 Reset release is synchronised externally; first accepted beat may be the cycle after deassertion.

Verification
REQ-033 WIDTH=24, add, a=0xFFFFFF, b=0x000001, c0=0, i_ready=1 -> 7 cycles later o_valid=1, o_s=0x000000, o_carry=1, o_ovf=0.
REQ-034 Subtract a=0x000005, b=0x000007 -> o_s=0xFFFFFE, o_carry=0, o_ovf=0; a=0x000007, b=0x000005 -> o_s=0x000002, o_carry=1.
REQ-035 Signed overflow: add 0x7FFFFF+0x000001 -> o_s=0x800000, o_ovf=1, o_carry=0; subtract 0x800000-0x000001 -> o_s=0x7FFFFF, o_ovf=1.
REQ-036 Stream 10 random beats back-to-back, drop i_ready for 3 cycles mid-stream -> o_ready=0 exactly while stalled, all 10 results correct, in order, output held stable during stall.
REQ-037 Accept 4 beats, assert i_rst_n=0 for 1 cycle before any emerges -> o_valid stays 0 for the following LAT+2 cycles.
REQ-038 Repeat REQ-033 random regression at WIDTH=2, 17, 32, 64 against a reference model -> latency LEVELS+2, zero mismatches over 10000 beats.
